// File: rtl/pi_result_tx.sv
// pi_result_tx: sends hash-core results to a Raspberry Pi as byte frames
// over a four-phase req/ack handshake.
// Frame: header (0xA5 found / 0x5A exhausted) followed by the nonce, MSB first.
// Optional feature macro PI_TX_CHECKSUM_EN appends an XOR checksum byte.
module pi_result_tx #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nonce_found,
    input  logic [31:0] nonce,
    input  logic        search_exhausted,
    input  logic        clear_err,
    input  logic        pi_ack,
    output logic [7:0]  tx_data,
    output logic        tx_req,
    output logic        busy,
    output logic        overflow_err,
    output logic        timeout_err
);

`ifdef PI_TX_CHECKSUM_EN
    localparam int FRAME_BYTES = 6;
`else
    localparam int FRAME_BYTES = 5;
`endif
    localparam int          REST_W    = (FRAME_BYTES - 1) * 8;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ack_meta_q, ack_s_q;
    logic                hold_valid_q, hold_valid_d;
    logic                hold_found_q, hold_found_d;
    logic [31:0]         hold_nonce_q, hold_nonce_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_req_q, tx_req_d;
    logic [REST_W-1:0]   rest_q, rest_d;
    logic [2:0]          bytes_left_q, bytes_left_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;

    logic                unload;
    logic                abort;
    logic                overflow_set;
    logic [7:0]          header;
    logic [REST_W-1:0]   rest_load;

    // Frame content derived from the held event: header plus remaining bytes
    always_comb begin
        header = hold_found_q ? 8'hA5 : 8'h5A;
`ifdef PI_TX_CHECKSUM_EN
        rest_load = {hold_nonce_q,
                     header ^ hold_nonce_q[31:24] ^ hold_nonce_q[23:16]
                            ^ hold_nonce_q[15:8]  ^ hold_nonce_q[7:0]};
`else
        rest_load = hold_nonce_q;
`endif
    end

    // Handshake FSM, holding register and sticky error flag next-state logic
    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_found_d = hold_found_q;
        hold_nonce_d = hold_nonce_q;
        tx_data_d    = tx_data_q;
        tx_req_d     = tx_req_q;
        rest_d       = rest_q;
        bytes_left_d = bytes_left_q;
        wait_cnt_d   = 16'd0;
        unload       = 1'b0;
        abort        = 1'b0;
        overflow_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    unload       = 1'b1;
                    tx_data_d    = header;
                    rest_d       = rest_load;
                    bytes_left_d = 3'(FRAME_BYTES - 1);
                    tx_req_d     = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (ack_s_q) begin
                    tx_req_d = 1'b0;
                    state_d  = RELEASE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    abort = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            RELEASE: begin
                if (!ack_s_q) begin
                    if (bytes_left_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        tx_data_d    = rest_q[REST_W-1 -: 8];
                        rest_d       = rest_q << 8;
                        bytes_left_d = bytes_left_q - 3'd1;
                        tx_req_d     = 1'b1;
                        state_d      = SEND;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    abort = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_req_d = 1'b0;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            tx_req_d   = 1'b0;
            wait_cnt_d = 16'd0;
        end

        if (nonce_found || search_exhausted) begin
            if (!hold_valid_q || unload) begin
                hold_valid_d = 1'b1;
                hold_found_d = nonce_found;
                hold_nonce_d = nonce_found ? nonce : 32'd0;
            end else begin
                overflow_set = 1'b1;
            end
        end else if (unload) begin
            hold_valid_d = 1'b0;
        end

        if (overflow_set)   overflow_d = 1'b1;
        else if (clear_err) overflow_d = 1'b0;
        else                overflow_d = overflow_q;

        if (abort)          timeout_d = 1'b1;
        else if (clear_err) timeout_d = 1'b0;
        else                timeout_d = timeout_q;
    end

    // State registers; reset drops tx_req immediately and abandons any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ack_meta_q   <= 1'b0;
            ack_s_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_found_q <= 1'b0;
            hold_nonce_q <= 32'd0;
            tx_data_q    <= 8'h00;
            tx_req_q     <= 1'b0;
            rest_q       <= '0;
            bytes_left_q <= 3'd0;
            wait_cnt_q   <= 16'd0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_meta_q   <= pi_ack;
            ack_s_q      <= ack_meta_q;
            hold_valid_q <= hold_valid_d;
            hold_found_q <= hold_found_d;
            hold_nonce_q <= hold_nonce_d;
            tx_data_q    <= tx_data_d;
            tx_req_q     <= tx_req_d;
            rest_q       <= rest_d;
            bytes_left_q <= bytes_left_d;
            wait_cnt_q   <= wait_cnt_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_req       = tx_req_q;
    assign busy         = (state_q != IDLE) || hold_valid_q;
    assign overflow_err = overflow_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_pi_result_tx.sv
// Testbench for pi_result_tx: a directed Pi model acknowledges bytes and
// each scenario task checks the observed frame against hand-built values.
module tb_pi_result_tx;

    localparam int TO = 16;
`ifdef PI_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic        clk;
    logic        rst;
    logic        nonce_found;
    logic [31:0] nonce;
    logic        search_exhausted;
    logic        clear_err;
    logic        pi_ack;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        busy;
    logic        overflow_err;
    logic        timeout_err;

    int          checks = 0;
    int          fails  = 0;
    int          hs_viol = 0;
    logic [7:0]  rx_bytes  [0:5];
    logic [7:0]  exp_bytes [0:5];
    logic [7:0]  prev_data;
    logic        prev_req;

    pi_result_tx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .nonce_found      (nonce_found),
        .nonce            (nonce),
        .search_exhausted (search_exhausted),
        .clear_err        (clear_err),
        .pi_ack           (pi_ack),
        .tx_data          (tx_data),
        .tx_req           (tx_req),
        .busy             (busy),
        .overflow_err     (overflow_err),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count tx_data changes that happen while the request was still raised
    always @(negedge clk) begin
        if (!rst) begin
            prev_req  = 1'b0;
            prev_data = 8'h00;
        end else begin
            if (tx_data !== prev_data && prev_req === 1'b1) hs_viol++;
            prev_req  = tx_req;
            prev_data = tx_data;
        end
    end

    // Hard time limit so a stuck design still ends the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic build_expected(input logic found, input logic [31:0] n);
        logic [31:0] p;
        p = found ? n : 32'd0;
        exp_bytes[0] = found ? 8'hA5 : 8'h5A;
        exp_bytes[1] = p[31:24];
        exp_bytes[2] = p[23:16];
        exp_bytes[3] = p[15:8];
        exp_bytes[4] = p[7:0];
        exp_bytes[5] = exp_bytes[0] ^ exp_bytes[1] ^ exp_bytes[2] ^ exp_bytes[3] ^ exp_bytes[4];
    endtask

    task automatic wait_req(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_req === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pi_receive(input int nbytes, output bit ok);
        bit got;
        ok = 1'b1;
        for (int b = 0; b < nbytes; b++) begin
            wait_req(1'b1, 100, got);
            if (!got) begin
                ok = 1'b0;
                return;
            end
            rx_bytes[b] = tx_data;
            @(negedge clk);
            pi_ack = 1'b1;
            wait_req(1'b0, 100, got);
            pi_ack = 1'b0;
            if (!got) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic pulse_event(input logic f, input logic e, input logic [31:0] n);
        @(negedge clk);
        nonce_found      = f;
        search_exhausted = e;
        nonce            = n;
        @(negedge clk);
        nonce_found      = 1'b0;
        search_exhausted = 1'b0;
        nonce            = 32'd0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_cycles(3);
        checks++; if (tx_req !== 1'b0)       begin fails++; $display("[TB] FAIL reset_tx_req: got %b want 0", tx_req); end
        checks++; if (tx_data !== 8'h00)     begin fails++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0)         begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow_err); end
        checks++; if (timeout_err !== 1'b0)  begin fails++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout_err); end
        rst = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_found;
        bit ok;
        build_expected(1'b1, 32'hDEADBEEF);
        pulse_event(1'b1, 1'b0, 32'hDEADBEEF);
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL found_busy_start: got %b want 1", busy); end
        pi_receive(NB, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL found_handshake: got ok=%b want 1", ok); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                fails++; $display("[TB] FAIL found_byte%0d: got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        idle_cycles(6);
        checks++; if (tx_req !== 1'b0) begin fails++; $display("[TB] FAIL found_req_end: got %b want 0", tx_req); end
        checks++; if (busy !== 1'b0)   begin fails++; $display("[TB] FAIL found_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_exhausted;
        bit ok;
        build_expected(1'b0, 32'd0);
        pulse_event(1'b0, 1'b1, 32'h12345678);
        pi_receive(NB, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL exh_handshake: got ok=%b want 1", ok); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                fails++; $display("[TB] FAIL exh_byte%0d: got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        idle_cycles(6);
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL exh_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_both;
        bit ok;
        build_expected(1'b1, 32'h00000001);
        pulse_event(1'b1, 1'b1, 32'h00000001);
        pi_receive(NB, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL both_handshake: got ok=%b want 1", ok); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                fails++; $display("[TB] FAIL both_byte%0d: got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        idle_cycles(30);
        checks++; if (busy !== 1'b0)         begin fails++; $display("[TB] FAIL both_no_second_frame: busy got %b want 0", busy); end
        checks++; if (overflow_err !== 1'b0) begin fails++; $display("[TB] FAIL both_overflow: got %b want 0", overflow_err); end
    endtask

    task automatic test_timeout_overflow;
        bit ok;
        int k;
        @(negedge clk);
        nonce_found = 1'b1; nonce = 32'h11223344;
        @(negedge clk);
        nonce = 32'h55667788;
        @(negedge clk);
        nonce_found = 1'b0; search_exhausted = 1'b1; nonce = 32'd0;
        @(negedge clk);
        search_exhausted = 1'b0;
        checks++; if (overflow_err !== 1'b1) begin fails++; $display("[TB] FAIL to_overflow_set: got %b want 1", overflow_err); end
        checks++; if (tx_req !== 1'b1)       begin fails++; $display("[TB] FAIL to_first_req: got %b want 1", tx_req); end
        checks++; if (tx_data !== 8'hA5)     begin fails++; $display("[TB] FAIL to_first_hdr: got %h want a5", tx_data); end
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                k = i;
                break;
            end
        end
        checks++; if (k < 15 || k > 18) begin fails++; $display("[TB] FAIL to_timeout_delay: got %0d cycles want 15..18", k); end
        checks++; if (tx_req !== 1'b0)  begin fails++; $display("[TB] FAIL to_req_dropped: got %b want 0", tx_req); end
        build_expected(1'b1, 32'h55667788);
        pi_receive(NB, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL to_held_handshake: got ok=%b want 1", ok); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                fails++; $display("[TB] FAIL to_held_byte%0d: got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        idle_cycles(10);
        checks++; if (busy !== 1'b0)         begin fails++; $display("[TB] FAIL to_dropped_not_sent: busy got %b want 0", busy); end
        checks++; if (overflow_err !== 1'b1) begin fails++; $display("[TB] FAIL to_overflow_sticky: got %b want 1", overflow_err); end
        checks++; if (timeout_err !== 1'b1)  begin fails++; $display("[TB] FAIL to_timeout_sticky: got %b want 1", timeout_err); end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        checks++; if (overflow_err !== 1'b0) begin fails++; $display("[TB] FAIL to_overflow_clear: got %b want 0", overflow_err); end
        checks++; if (timeout_err !== 1'b0)  begin fails++; $display("[TB] FAIL to_timeout_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        bit got;
        pulse_event(1'b1, 1'b0, 32'hCAFEF00D);
        pi_receive(2, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_first_bytes: got ok=%b want 1", ok); end
        wait_req(1'b1, 100, got);
        checks++; if (got !== 1'b1)      begin fails++; $display("[TB] FAIL rstmid_byte2_req: got %b want 1", got); end
        checks++; if (tx_data !== 8'hFE) begin fails++; $display("[TB] FAIL rstmid_byte2_data: got %h want fe", tx_data); end
        #2 rst = 1'b0;
        #1;
        checks++; if (tx_req !== 1'b0)   begin fails++; $display("[TB] FAIL rstmid_req_async: got %b want 0", tx_req); end
        checks++; if (tx_data !== 8'h00) begin fails++; $display("[TB] FAIL rstmid_data_async: got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0)     begin fails++; $display("[TB] FAIL rstmid_busy_async: got %b want 0", busy); end
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(5);
        checks++; if (tx_req !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_no_resume: got %b want 0", tx_req); end
        build_expected(1'b0, 32'd0);
        pulse_event(1'b0, 1'b1, 32'd0);
        pi_receive(NB, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_after_handshake: got ok=%b want 1", ok); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                fails++; $display("[TB] FAIL rstmid_after_byte%0d: got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        idle_cycles(6);
    endtask

    task automatic test_handshake_rule;
        checks++;
        if (hs_viol !== 0) begin
            fails++; $display("[TB] FAIL data_stable_while_req: got %0d changes want 0", hs_viol);
        end
    endtask

    initial begin
        rst              = 1'b0;
        nonce_found      = 1'b0;
        nonce            = 32'd0;
        search_exhausted = 1'b0;
        clear_err        = 1'b0;
        pi_ack           = 1'b0;
        test_reset;
        test_found;
        test_exhausted;
        test_both;
        test_timeout_overflow;
        test_reset_midframe;
        test_handshake_rule;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
